// File: rtl/cdb_arbiter.sv
// cdb_arbiter: writeback (common data bus) arbiter.
//
// Each functional unit pushes completed results into its own small circular
// FIFO over a valid/ready handshake. Every cycle one non-empty FIFO is chosen
// round-robin. Its head entry is loaded into the registered CDB outputs.
// A flush discards everything that is buffered, plus the result that was
// selected in the flush cycle.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   flush                 squash all buffered and outgoing results
//   fu_valid / fu_ready   per-source push handshake
//   fu_prd/rob/data/br    per-source result payload, packed source-major
//   cdb_valid             broadcast valid (registered)
//   cdb_prd/rob/data/br   broadcast payload; holds its last value when idle
//   cdb_src               index of the source that won the broadcast
module cdb_arbiter #(
   parameter int NUM_FU = 4,
   parameter int DATA_W = 32,
   parameter int PRD_W  = 6,
   parameter int ROB_W  = 5,
   parameter int DEPTH  = 2,
   localparam int SRC_W = $clog2(NUM_FU)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [NUM_FU-1:0]          fu_valid,
   output logic [NUM_FU-1:0]          fu_ready,
   input  logic [NUM_FU*PRD_W-1:0]    fu_prd,
   input  logic [NUM_FU*ROB_W-1:0]    fu_rob,
   input  logic [NUM_FU*DATA_W-1:0]   fu_data,
   input  logic [NUM_FU-1:0]          fu_br,
   output logic                       cdb_valid,
   output logic [PRD_W-1:0]           cdb_prd,
   output logic [ROB_W-1:0]           cdb_rob,
   output logic [DATA_W-1:0]          cdb_data,
   output logic                       cdb_br,
   output logic [SRC_W-1:0]           cdb_src
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = PRD_W + ROB_W + DATA_W + 1;

   logic [ENT_W-1:0]  mem  [NUM_FU][DEPTH];
   logic [PTR_W-1:0]  head [NUM_FU];
   logic [PTR_W-1:0]  tail [NUM_FU];
   logic [CNT_W-1:0]  cnt  [NUM_FU];
   logic [SRC_W-1:0]  rr_ptr;

   logic [NUM_FU-1:0] push;
   logic [NUM_FU-1:0] pop;
   logic              grant_valid;
   logic [SRC_W-1:0]  grant_idx;
   logic [SRC_W-1:0]  rr_next;
   logic [ENT_W-1:0]  head_ent;

   // Ready looks only at the registered count: a full FIFO refuses a push
   // even if it is being popped in the same cycle.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         fu_ready[i] = (cnt[i] < CNT_W'(DEPTH)) & ~flush & ~rst;
      end
   end

   assign push = fu_valid & fu_ready;

   // Round-robin search from rr_ptr upward, wrapping modulo NUM_FU.
   always_comb begin
      logic [SRC_W-1:0] sel;
      grant_valid = 1'b0;
      grant_idx   = '0;
      sel         = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         sel = SRC_W'((int'(rr_ptr) + k) % NUM_FU);
         if (!grant_valid && cnt[sel] != '0) begin
            grant_valid = 1'b1;
            grant_idx   = sel;
         end
      end
      pop = '0;
      if (grant_valid) pop[grant_idx] = 1'b1;
      head_ent = mem[grant_idx][head[grant_idx]];
      rr_next  = (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + SRC_W'(1);
   end

   // Storage has no reset; head/tail/count decide what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (push[i]) begin
            mem[i][tail[i]] <= {fu_prd[i*PRD_W +: PRD_W], fu_rob[i*ROB_W +: ROB_W],
                                fu_data[i*DATA_W +: DATA_W], fu_br[i]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_FU; i++) begin
            head[i] <= '0;
            tail[i] <= '0;
            cnt[i]  <= '0;
         end
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_prd   <= '0;
         cdb_rob   <= '0;
         cdb_data  <= '0;
         cdb_br    <= 1'b0;
         cdb_src   <= '0;
      end else if (flush) begin
         // rr_ptr and the payload registers keep their values.
         for (int i = 0; i < NUM_FU; i++) begin
            head[i] <= '0;
            tail[i] <= '0;
            cnt[i]  <= '0;
         end
         cdb_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) tail[i] <= tail[i] + PTR_W'(1);
            if (pop[i])  head[i] <= head[i] + PTR_W'(1);
            if (push[i] && !pop[i])      cnt[i] <= cnt[i] + CNT_W'(1);
            else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - CNT_W'(1);
         end
         cdb_valid <= grant_valid;
         if (grant_valid) begin
            {cdb_prd, cdb_rob, cdb_data, cdb_br} <= head_ent;
            cdb_src <= grant_idx;
            rr_ptr  <= rr_next;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter. A queue-per-source reference model
// predicts fu_ready and the CDB outputs cycle by cycle. Directed scenarios
// come first, followed by randomized traffic with occasional flush/reset.
module tb_cdb_arbiter;

   localparam int NUM_FU = 4;
   localparam int DATA_W = 32;
   localparam int PRD_W  = 6;
   localparam int ROB_W  = 5;
   localparam int DEPTH  = 2;
   localparam int SRC_W  = $clog2(NUM_FU);
   localparam int ENT_W  = PRD_W + ROB_W + DATA_W + 1;

   typedef logic [ENT_W-1:0] ent_t;

   logic                     clk;
   logic                     rst;
   logic                     flush;
   logic [NUM_FU-1:0]        fu_valid;
   logic [NUM_FU-1:0]        fu_ready;
   logic [NUM_FU*PRD_W-1:0]  fu_prd;
   logic [NUM_FU*ROB_W-1:0]  fu_rob;
   logic [NUM_FU*DATA_W-1:0] fu_data;
   logic [NUM_FU-1:0]        fu_br;
   logic                     cdb_valid;
   logic [PRD_W-1:0]         cdb_prd;
   logic [ROB_W-1:0]         cdb_rob;
   logic [DATA_W-1:0]        cdb_data;
   logic                     cdb_br;
   logic [SRC_W-1:0]         cdb_src;

   cdb_arbiter #(
      .NUM_FU(NUM_FU), .DATA_W(DATA_W), .PRD_W(PRD_W), .ROB_W(ROB_W), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .fu_valid(fu_valid), .fu_ready(fu_ready),
      .fu_prd(fu_prd), .fu_rob(fu_rob), .fu_data(fu_data), .fu_br(fu_br),
      .cdb_valid(cdb_valid), .cdb_prd(cdb_prd), .cdb_rob(cdb_rob),
      .cdb_data(cdb_data), .cdb_br(cdb_br), .cdb_src(cdb_src)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   ent_t q [NUM_FU][$];
   int   rr      = 0;
   logic e_valid = 1'b0;
   ent_t e_ent   = '0;
   int   e_src   = 0;
   int   n_results = 0;
   int   n_pushes  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_payload(input int s, input logic [PRD_W-1:0] prd,
                              input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] data,
                              input logic br);
      fu_prd[s*PRD_W +: PRD_W]    = prd;
      fu_rob[s*ROB_W +: ROB_W]    = rob;
      fu_data[s*DATA_W +: DATA_W] = data;
      fu_br[s]                    = br;
   endtask

   // One clock: drive inputs after the falling edge, check ready, advance the
   // model across the rising edge, then check the registered CDB outputs.
   task automatic cycle(input logic [NUM_FU-1:0] v, input logic fl, input logic rs,
                        input bit rand_pl);
      logic [NUM_FU-1:0] exp_rdy;
      int win;
      int s;
      @(negedge clk);
      fu_valid = v;
      flush    = fl;
      rst      = rs;
      if (rand_pl) begin
         for (int i = 0; i < NUM_FU; i++) begin
            set_payload(i, PRD_W'($urandom), ROB_W'($urandom), $urandom, 1'($urandom));
         end
      end
      #1;
      for (int i = 0; i < NUM_FU; i++) begin
         exp_rdy[i] = (q[i].size() < DEPTH) && !fl && !rs;
      end
      chk("fu_ready", 64'(fu_ready), 64'(exp_rdy));

      if (rs) begin
         for (int i = 0; i < NUM_FU; i++) q[i].delete();
         rr = 0; e_valid = 1'b0; e_ent = '0; e_src = 0;
      end else if (fl) begin
         for (int i = 0; i < NUM_FU; i++) q[i].delete();
         e_valid = 1'b0;
      end else begin
         win = -1;
         for (int k = 0; k < NUM_FU; k++) begin
            s = (rr + k) % NUM_FU;
            if (win < 0 && q[s].size() > 0) win = s;
         end
         if (win >= 0) begin
            e_ent   = q[win].pop_front();
            e_src   = win;
            e_valid = 1'b1;
            rr      = (win + 1) % NUM_FU;
            n_results++;
         end else begin
            e_valid = 1'b0;
         end
         for (int i = 0; i < NUM_FU; i++) begin
            if (v[i] && exp_rdy[i]) begin
               q[i].push_back({fu_prd[i*PRD_W +: PRD_W], fu_rob[i*ROB_W +: ROB_W],
                               fu_data[i*DATA_W +: DATA_W], fu_br[i]});
               n_pushes++;
            end
         end
      end

      @(posedge clk);
      #1;
      chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
      chk("cdb_prd",   64'(cdb_prd),   64'(e_ent[ENT_W-1 -: PRD_W]));
      chk("cdb_rob",   64'(cdb_rob),   64'(e_ent[DATA_W+1 +: ROB_W]));
      chk("cdb_data",  64'(cdb_data),  64'(e_ent[1 +: DATA_W]));
      chk("cdb_br",    64'(cdb_br),    64'(e_ent[0]));
      chk("cdb_src",   64'(cdb_src),   64'(e_src));
   endtask

   initial begin
      int d;
      int base;
      rst = 1'b1; flush = 1'b0; fu_valid = '0;
      fu_prd = '0; fu_rob = '0; fu_data = '0; fu_br = '0;

      // reset values
      cycle('0, 1'b0, 1'b1, 1'b1);
      cycle('0, 1'b0, 1'b1, 1'b1);
      chk("rst_valid", 64'(cdb_valid), 64'd0);
      chk("rst_data",  64'(cdb_data),  64'd0);
      chk("rst_src",   64'(cdb_src),   64'd0);
      cycle('0, 1'b0, 1'b0, 1'b0);
      chk("ready_after_rst", 64'(fu_ready), 64'hF);

      // single result from source 2
      set_payload(2, 6'd5, 5'd3, 32'hDEADBEEF, 1'b0);
      cycle(4'b0100, 1'b0, 1'b0, 1'b0);
      chk("single_not_yet", 64'(cdb_valid), 64'd0);
      cycle('0, 1'b0, 1'b0, 1'b0);
      chk("single_valid", 64'(cdb_valid), 64'd1);
      chk("single_src",   64'(cdb_src),   64'd2);
      chk("single_data",  64'(cdb_data),  64'hDEADBEEF);
      chk("single_prd",   64'(cdb_prd),   64'd5);
      chk("single_rob",   64'(cdb_rob),   64'd3);
      cycle('0, 1'b0, 1'b0, 1'b0);
      chk("single_done", 64'(cdb_valid), 64'd0);

      // round robin from rr_ptr = 0
      cycle('0, 1'b0, 1'b1, 1'b1);
      cycle(4'b1111, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < NUM_FU; k++) begin
         cycle('0, 1'b0, 1'b0, 1'b1);
         chk("rr_valid", 64'(cdb_valid), 64'd1);
         chk("rr_src",   64'(cdb_src),   64'(k));
      end
      cycle(4'b1000, 1'b0, 1'b0, 1'b1);
      cycle('0, 1'b0, 1'b0, 1'b1);
      chk("rr_wrap", 64'(cdb_src), 64'd3);

      // sources 0 and 1 pushing every cycle
      base = n_results;
      for (int c = 0; c < 220; c++) cycle(4'b0011, 1'b0, 1'b0, 1'b1);
      chk("bp_results", 64'(n_results - base >= 100), 64'd1);

      // flush with three sources holding entries and a broadcast in flight
      cycle(4'b0111, 1'b0, 1'b0, 1'b1);
      cycle(4'b0111, 1'b0, 1'b0, 1'b1);
      chk("pre_flush_valid", 64'(cdb_valid), 64'd1);
      cycle(4'b1111, 1'b1, 1'b0, 1'b1);
      chk("flush_valid", 64'(cdb_valid), 64'd0);
      for (int c = 0; c < 4; c++) cycle('0, 1'b0, 1'b0, 1'b1);

      // fill everything, reset mid-operation, refill
      for (int c = 0; c < 6; c++) cycle(4'b1111, 1'b0, 1'b0, 1'b1);
      cycle(4'b1111, 1'b0, 1'b1, 1'b1);
      chk("rst_mid_valid", 64'(cdb_valid), 64'd0);
      chk("rst_mid_prd",   64'(cdb_prd),   64'd0);
      cycle(4'b1010, 1'b0, 1'b0, 1'b1);
      cycle(4'b0000, 1'b0, 1'b0, 1'b1);
      chk("rst_mid_first", 64'(cdb_src), 64'd1);

      // randomized traffic at several densities
      for (int c = 0; c < 3000; c++) begin
         logic [NUM_FU-1:0] v;
         d = (c / 500) % 4;
         for (int i = 0; i < NUM_FU; i++) v[i] = ($urandom_range(3) < d + 1) ? 1'b1 : 1'b0;
         cycle(v, ($urandom_range(99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(199) == 0) ? 1'b1 : 1'b0, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
